// File: rtl/npu_result_reader_pkg.sv
// Shared constants for the NPU result reader: FSM state codes, FIFO read
// latency and the default low-byte timeout.
package npu_result_reader_pkg;

    typedef logic [2:0] rd_state_t;

    localparam rd_state_t ST_IDLE    = 3'd0;
    localparam rd_state_t ST_RD_HI   = 3'd1;
    localparam rd_state_t ST_CAP_HI  = 3'd2;
    localparam rd_state_t ST_RD_LO   = 3'd3;
    localparam rd_state_t ST_CAP_LO  = 3'd4;
    localparam rd_state_t ST_PRESENT = 3'd5;
    localparam rd_state_t ST_FIN     = 3'd6;

    // FIFO data_out is valid this many cycles after rd_en; the CAP_* states assume 1.
    localparam int RD_LATENCY = 1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/npu_rd_timer.sv
// Clearable saturating cycle counter; expired_o flags the increment that
// brings the count to LIMIT.
module npu_rd_timer #(
    parameter int LIMIT = 16,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic CLKEXT,
    input  logic RST_GLO,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != W'(LIMIT))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = inc_i && !clr_i && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/npu_result_reader.sv
// Pops high-then-low bytes from the NPU output FIFO and presents 16-bit
// results on a valid/ready port, with word counting, last flag and timeout.
module npu_result_reader
    import npu_result_reader_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int CNT_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    CLKEXT,
    input  logic                    RST_GLO,
    input  logic                    EN_RD,
    input  logic                    ABORT,
    input  logic [CNT_WIDTH-1:0]    WORD_COUNT,
    input  logic                    CLR_ERR,
    input  logic                    FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0]   FIFO_DATA,
    output logic                    FIFO_RD_EN,
    output logic [2*DATA_WIDTH-1:0] RES_DATA,
    output logic                    RES_VALID,
    input  logic                    RES_READY,
    output logic                    RES_LAST,
    output logic [CNT_WIDTH-1:0]    WORDS_READ,
    output logic                    BUSY_RD,
    output logic                    DONE_RD,
    output logic                    ERR_TIMEOUT,
    output logic [2:0]              DBG_STATE
);

    // Result port: a result transfers on a cycle where RES_VALID and RES_READY
    // are both high; while RES_VALID waits for RES_READY, RES_DATA/RES_LAST hold.

    rd_state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0]    words_read_q, words_read_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [2*DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                    err_q, err_d;

    logic drain_mode;
    logic last_word;
    logic tmr_clr;
    logic tmr_inc;
    logic tmr_expired;

    assign drain_mode = (word_cnt_q == '0);
    assign last_word  = !drain_mode && (words_read_q == word_cnt_q - CNT_WIDTH'(1));
    assign tmr_clr    = (state_q == ST_CAP_HI);
    assign tmr_inc    = (state_q == ST_RD_LO) && FIFO_EMPTY && !ABORT;

    npu_rd_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .CLKEXT    (CLKEXT),
        .RST_GLO   (RST_GLO),
        .clr_i     (tmr_clr),
        .inc_i     (tmr_inc),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (EN_RD) state_d = ST_RD_HI;
                ST_RD_HI: begin
                    if (!FIFO_EMPTY)     state_d = ST_CAP_HI;
                    else if (drain_mode) state_d = ST_FIN;
                end
                ST_CAP_HI:  state_d = ST_RD_LO;
                ST_RD_LO: begin
                    if (!FIFO_EMPTY)      state_d = ST_CAP_LO;
                    else if (tmr_expired) state_d = ST_FIN;
                end
                ST_CAP_LO:  state_d = ST_PRESENT;
                ST_PRESENT: if (RES_READY) state_d = last_word ? ST_FIN : ST_RD_HI;
                ST_FIN:     state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        FIFO_RD_EN = 1'b0;
        RES_VALID  = 1'b0;
        RES_LAST   = 1'b0;
        BUSY_RD    = (state_q != ST_IDLE);
        DONE_RD    = (state_q == ST_FIN);
        case (state_q)
            ST_RD_HI, ST_RD_LO: FIFO_RD_EN = !FIFO_EMPTY && !ABORT;
            ST_PRESENT: begin
                RES_VALID = 1'b1;
                RES_LAST  = last_word;
            end
            default: ;
        endcase
    end

    // Abort freezes the datapath; only the error flag's clear path stays live.
    always_comb begin
        word_cnt_d   = word_cnt_q;
        words_read_d = words_read_q;
        hi_d         = hi_q;
        res_data_d   = res_data_q;
        err_d        = err_q;
        if (tmr_expired) begin
            err_d = 1'b1;
        end else if (CLR_ERR) begin
            err_d = 1'b0;
        end
        if (!ABORT) begin
            case (state_q)
                ST_IDLE: begin
                    if (EN_RD) begin
                        word_cnt_d   = WORD_COUNT;
                        words_read_d = '0;
                    end
                end
                ST_CAP_HI:  hi_d = FIFO_DATA;
                ST_RD_LO:   if (tmr_expired) hi_d = '0;
                ST_CAP_LO:  res_data_d = {hi_q, FIFO_DATA};
                ST_PRESENT: begin
                    if (RES_READY && (words_read_q != '1)) begin
                        words_read_d = words_read_q + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLKEXT or posedge RST_GLO) begin
        if (RST_GLO) begin
            word_cnt_q   <= '0;
            words_read_q <= '0;
            hi_q         <= '0;
            res_data_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            word_cnt_q   <= word_cnt_d;
            words_read_q <= words_read_d;
            hi_q         <= hi_d;
            res_data_q   <= res_data_d;
            err_q        <= err_d;
        end
    end

    assign RES_DATA    = res_data_q;
    assign WORDS_READ  = words_read_q;
    assign ERR_TIMEOUT = err_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_npu_result_reader.sv
// Directed bench for npu_result_reader: FIFO model, expected-result queue
// checked by a negedge monitor, and a cycle-accurate set of directed tests.
module tb_npu_result_reader;
  import npu_result_reader_pkg::*;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO;
  logic        EN_RD;
  logic        ABORT;
  logic [7:0]  WORD_COUNT;
  logic        CLR_ERR;
  logic        FIFO_EMPTY = 1'b1;
  logic [7:0]  FIFO_DATA = 8'h00;
  logic        FIFO_RD_EN;
  logic [15:0] RES_DATA;
  logic        RES_VALID;
  logic        RES_READY;
  logic        RES_LAST;
  logic [7:0]  WORDS_READ;
  logic        BUSY_RD;
  logic        DONE_RD;
  logic        ERR_TIMEOUT;
  logic [2:0]  DBG_STATE;

  npu_result_reader dut (
    .CLKEXT      (CLKEXT),
    .RST_GLO     (RST_GLO),
    .EN_RD       (EN_RD),
    .ABORT       (ABORT),
    .WORD_COUNT  (WORD_COUNT),
    .CLR_ERR     (CLR_ERR),
    .FIFO_EMPTY  (FIFO_EMPTY),
    .FIFO_DATA   (FIFO_DATA),
    .FIFO_RD_EN  (FIFO_RD_EN),
    .RES_DATA    (RES_DATA),
    .RES_VALID   (RES_VALID),
    .RES_READY   (RES_READY),
    .RES_LAST    (RES_LAST),
    .WORDS_READ  (WORDS_READ),
    .BUSY_RD     (BUSY_RD),
    .DONE_RD     (DONE_RD),
    .ERR_TIMEOUT (ERR_TIMEOUT),
    .DBG_STATE   (DBG_STATE)
  );

  // clock / reset
  always #5 CLKEXT = ~CLKEXT;

  logic [7:0]  fifo_q[$];
  logic [16:0] exp_q[$];   // {last, data}
  int n_vec = 0;
  int n_err = 0;
  int rd_en_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int edges = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // FIFO model: data_out registered one cycle after rd_en
  always @(posedge CLKEXT) begin
    if (FIFO_RD_EN) begin
      rd_en_cnt++;
      if (fifo_q.size() > 0) begin
        FIFO_DATA <= fifo_q.pop_front();
      end else begin
        n_vec++;
        n_err++;
        $display("FAIL pop_on_empty: rd_en=1 with empty FIFO (t=%0t)", $time);
      end
    end
    FIFO_EMPTY <= (fifo_q.size() == 0);
  end

  // scoreboard monitor
  always @(negedge CLKEXT) begin
    if (!RST_GLO) begin
      if (DONE_RD) done_cnt++;
      if (RES_VALID) begin
        valid_cnt++;
        check("rd_en_in_present", {31'd0, FIFO_RD_EN}, 32'd0);
        if (RES_READY) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got 0x%0h, expected none", RES_DATA);
          end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            check("res_data", {16'd0, RES_DATA}, {16'd0, e[15:0]});
            check("res_last", {31'd0, RES_LAST}, {31'd0, e[16]});
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLKEXT);
    #1;
  endtask

  task automatic start(input logic [7:0] wc);
    WORD_COUNT = wc;
    EN_RD = 1'b1;
    tick();
    EN_RD = 1'b0;
    WORD_COUNT = 8'hEE;
    edges = 1;
  endtask

  task automatic wait_done(input int limit);
    while (!DONE_RD && edges < limit) begin
      tick();
      edges++;
    end
    if (!DONE_RD) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!RES_VALID && n < limit) begin
      tick();
      n++;
    end
    if (!RES_VALID) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_counts();
    rd_en_cnt = 0;
    done_cnt = 0;
    valid_cnt = 0;
  endtask

  initial begin
    RST_GLO = 1'b1;
    EN_RD = 1'b0;
    ABORT = 1'b0;
    WORD_COUNT = 8'd0;
    CLR_ERR = 1'b0;
    RES_READY = 1'b1;
    #1;
    check("reset_outputs", {FIFO_RD_EN, RES_VALID, RES_LAST, BUSY_RD, DONE_RD, ERR_TIMEOUT}, 32'd0);
    check("reset_data", {RES_DATA, WORDS_READ}, 32'd0);
    tick();
    tick();
    RST_GLO = 1'b0;
    tick();
    check("idle_state", {29'd0, DBG_STATE}, {29'd0, ST_IDLE});

    // fixed-count transfer of two results
    clear_counts();
    fifo_q.push_back(8'h12); fifo_q.push_back(8'h34);
    fifo_q.push_back(8'hAB); fifo_q.push_back(8'hCD);
    exp_q.push_back({1'b0, 16'h1234});
    exp_q.push_back({1'b1, 16'hABCD});
    tick();
    start(8'd2);
    wait_done(40);
    check("fixed_edges_to_fin", edges, 32'd11);
    tick(); tick();
    check("fixed_done_cnt", done_cnt, 32'd1);
    check("fixed_words_read", {24'd0, WORDS_READ}, 32'd2);
    check("fixed_rd_en_cnt", rd_en_cnt, 32'd4);
    check("fixed_exp_left", exp_q.size(), 32'd0);
    check("fixed_busy_after", {31'd0, BUSY_RD}, 32'd0);

    // drain mode, six bytes
    clear_counts();
    for (int i = 1; i <= 6; i++) fifo_q.push_back(8'(i));
    exp_q.push_back({1'b0, 16'h0102});
    exp_q.push_back({1'b0, 16'h0304});
    exp_q.push_back({1'b0, 16'h0506});
    tick();
    start(8'd0);
    wait_done(60);
    check("drain_edges_to_fin", edges, 32'd17);
    tick(); tick();
    check("drain_done_cnt", done_cnt, 32'd1);
    check("drain_words_read", {24'd0, WORDS_READ}, 32'd3);
    check("drain_rd_en_cnt", rd_en_cnt, 32'd6);
    check("drain_exp_left", exp_q.size(), 32'd0);

    // backpressure on the first result
    clear_counts();
    RES_READY = 1'b0;
    fifo_q.push_back(8'h12); fifo_q.push_back(8'h34);
    fifo_q.push_back(8'hAB); fifo_q.push_back(8'hCD);
    exp_q.push_back({1'b0, 16'h1234});
    exp_q.push_back({1'b1, 16'hABCD});
    tick();
    start(8'd2);
    wait_valid(20);
    for (int i = 0; i < 7; i++) begin
      check("bp_valid_held", {31'd0, RES_VALID}, 32'd1);
      check("bp_data_held", {16'd0, RES_DATA}, 32'h1234);
      check("bp_last_low", {31'd0, RES_LAST}, 32'd0);
      tick();
    end
    check("bp_rd_en_cnt", rd_en_cnt, 32'd2);
    RES_READY = 1'b1;
    wait_done(60);
    tick(); tick();
    check("bp_words_read", {24'd0, WORDS_READ}, 32'd2);
    check("bp_exp_left", exp_q.size(), 32'd0);

    // low-byte timeout
    clear_counts();
    fifo_q.push_back(8'h55);
    tick();
    start(8'd1);
    wait_done(60);
    check("to_edges_to_fin", edges, 32'd19);
    check("to_err_set", {31'd0, ERR_TIMEOUT}, 32'd1);
    tick(); tick();
    check("to_done_cnt", done_cnt, 32'd1);
    check("to_valid_cnt", valid_cnt, 32'd0);
    check("to_words_read", {24'd0, WORDS_READ}, 32'd0);
    check("to_err_sticky", {31'd0, ERR_TIMEOUT}, 32'd1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    check("to_err_cleared", {31'd0, ERR_TIMEOUT}, 32'd0);

    // abort in RD_LO with data available
    clear_counts();
    fifo_q.push_back(8'h12); fifo_q.push_back(8'h34);
    fifo_q.push_back(8'hAB); fifo_q.push_back(8'hCD);
    tick();
    start(8'd2);
    tick(); tick();
    check("abort_in_rd_lo", {29'd0, DBG_STATE}, {29'd0, ST_RD_LO});
    ABORT = 1'b1;
    #1;
    check("abort_no_rd_en", {31'd0, FIFO_RD_EN}, 32'd0);
    tick();
    ABORT = 1'b0;
    check("abort_state_idle", {29'd0, DBG_STATE}, {29'd0, ST_IDLE});
    check("abort_busy_low", {31'd0, BUSY_RD}, 32'd0);
    tick(); tick(); tick();
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_words_held", {24'd0, WORDS_READ}, 32'd0);
    fifo_q.delete();
    fifo_q.push_back(8'h9A); fifo_q.push_back(8'hBC);
    exp_q.push_back({1'b1, 16'h9ABC});
    tick();
    start(8'd1);
    wait_done(40);
    tick(); tick();
    check("restart_words_read", {24'd0, WORDS_READ}, 32'd1);
    check("restart_exp_left", exp_q.size(), 32'd0);
    check("restart_done_cnt", done_cnt, 32'd1);

    // asynchronous reset while presenting
    RES_READY = 1'b0;
    fifo_q.push_back(8'h12); fifo_q.push_back(8'h34);
    exp_q.push_back({1'b1, 16'h1234});
    tick();
    start(8'd1);
    wait_valid(20);
    RST_GLO = 1'b1;
    #1;
    check("rst_mid_flags", {FIFO_RD_EN, RES_VALID, RES_LAST, BUSY_RD, DONE_RD, ERR_TIMEOUT}, 32'd0);
    check("rst_mid_data", {RES_DATA, WORDS_READ}, 32'd0);
    check("rst_mid_state", {29'd0, DBG_STATE}, {29'd0, ST_IDLE});
    exp_q.delete();
    tick();
    RST_GLO = 1'b0;
    RES_READY = 1'b1;
    clear_counts();
    fifo_q.push_back(8'h56); fifo_q.push_back(8'h78);
    exp_q.push_back({1'b1, 16'h5678});
    tick();
    start(8'd1);
    wait_done(40);
    tick(); tick();
    check("post_rst_words_read", {24'd0, WORDS_READ}, 32'd1);
    check("post_rst_exp_left", exp_q.size(), 32'd0);
    check("post_rst_rd_en_cnt", rd_en_cnt, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
